pico_bus_if: RTL and testbench

Front-end between the Pico 8-bit parallel bus and the SIMD core. It synchronizes the asynchronous CS/WR/RD/CD/excute strobes and decodes address and data writes into operand-memory write pulses and a mode register. It issues a single-cycle start to the core and streams the core's result buffer back to the Pico, one byte per RD strobe. Sits directly upstream of the SIMD datapath inside TOP.

---
 rtl/pico_bus_if_if.sv | 23 ++
 rtl/pico_bus_if.sv | 158 +++++++++++++++
 tb/tb_pico_bus_if.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pico_bus_if_if.sv
// Pico 8-bit parallel bus bundle between the Pico and the bus front-end.
// master = Pico side (drives strobes), slave = FPGA front-end.
interface pico_bus_if_if;
    logic       cs;
    logic       wr;
    logic       rd;
    logic       cd;
    logic       excute;
    logic       dir;
    logic [7:0] pico_din;
    logic [7:0] pico_dout;
    logic       pico_oe;

    modport master (
        output cs, wr, rd, cd, excute, dir, pico_din,
        input  pico_dout, pico_oe
    );

    modport slave (
        input  cs, wr, rd, cd, excute, dir, pico_din,
        output pico_dout, pico_oe
    );
endinterface

// File: rtl/pico_bus_if.sv
// Pico bus front-end: strobe sync, operand/mode writes, start/busy, result readback.
// Optional ADDR_AUTOINC_EN: address latch steps by 1 after each operand write.
module pico_bus_if #(
    parameter int MODE_ADDR = 64,
    parameter int RD_DEPTH  = 64,
    parameter int PTR_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    pico_bus_if_if.slave     bus,
    output logic             wr_en,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic [7:0]       mode,
    output logic             start,
    input  logic             done,
    output logic             busy,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             err
);
    localparam logic [7:0]       MODE_A  = 8'(MODE_ADDR);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RD_DEPTH - 1);

    logic [13:0] raw, s1_q, s2_q;
    logic [2:0]  e_q;
    logic [1:0]  warm_q, warm_d;

    logic       cs_s, wr_s, rd_s, cd_s, ex_s, dir_s;
    logic [7:0] din_s;
    logic       live, wr_rise, rd_fall, ex_rise, busy_now;

    logic [7:0]       addr_q, addr_d;
    logic [7:0]       mode_q, mode_d;
    logic             wr_en_q, wr_en_d;
    logic [7:0]       wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic [7:0]       dout_q;
    logic             oe_q;

    assign raw = {bus.cs, bus.wr, bus.rd, bus.cd,
                  bus.excute, bus.dir, bus.pico_din};

    assign cs_s  = s2_q[13];
    assign wr_s  = s2_q[12];
    assign rd_s  = s2_q[11];
    assign cd_s  = s2_q[10];
    assign ex_s  = s2_q[9];
    assign dir_s = s2_q[8];
    assign din_s = s2_q[7:0];

    // Edges are ignored until the edge register holds a real post-reset
    // sample, so a strobe held across reset release is not seen as a rise.
    assign live    = (warm_q == 2'd3);
    assign wr_rise = live & cs_s & wr_s & ~e_q[2];
    assign rd_fall = live & cs_s & ~rd_s & e_q[1];
    assign ex_rise = live & cs_s & ex_s & ~e_q[0];

    assign busy_now = busy_q & ~done;
    assign warm_d   = live ? warm_q : warm_q + 2'd1;

    always_comb begin
        addr_d    = addr_q;
        mode_d    = mode_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        busy_d    = busy_now;
        ptr_d     = ptr_q;
        err_d     = err_q;
        if (wr_rise) begin
            if (busy_now) begin
                err_d = 1'b1;
            end else if (cd_s) begin
                addr_d = din_s;
            end else if (addr_q == MODE_A) begin
                mode_d = din_s;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = din_s;
`ifdef ADDR_AUTOINC_EN
                addr_d    = addr_q + 8'd1;
`else
                addr_d    = addr_q;
`endif
            end
            if (rd_fall) err_d = 1'b1;
        end else if (rd_fall) begin
            if (busy_now) begin
                err_d = 1'b1;
            end else begin
                ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
            end
        end
        if (ex_rise) begin
            if (busy_now) begin
                err_d = 1'b1;
            end else begin
                start_d = 1'b1;
                busy_d  = 1'b1;
                ptr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            e_q       <= '0;
            warm_q    <= '0;
            addr_q    <= '0;
            mode_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            err_q     <= 1'b0;
            dout_q    <= '0;
            oe_q      <= 1'b0;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            e_q       <= {wr_s, rd_s, ex_s};
            warm_q    <= warm_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            dout_q    <= rd_data;
            oe_q      <= cs_s & dir_s;
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign mode          = mode_q;
    assign start         = start_q;
    assign busy          = busy_q;
    assign rd_addr       = ptr_q;
    assign err           = err_q;
    assign bus.pico_dout = dout_q;
    assign bus.pico_oe   = oe_q;
endmodule

// File: tb/tb_pico_bus_if.sv
// Bench for pico_bus_if: vector table, directed corner sequences, random ops.
// Reference model tracks latch/mode/busy/err/pointer from the bus rules.
`timescale 1ns/1ps
module tb_pico_bus_if;
    localparam int DEPTH = 64;
    localparam logic [7:0] MODE_A = 8'h40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pico_bus_if_if bus();
    logic       wr_en, start, done, busy, err;
    logic [7:0] wr_addr, wr_data, mode, rd_data;
    logic [5:0] rd_addr;

    pico_bus_if dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mode(mode), .start(start), .done(done), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data), .err(err)
    );

    logic [7:0] mem [DEPTH];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } wev_t;
    wev_t wq[$];
    int   sq[$];

    always @(posedge clk) begin
        wev_t e;
        #1;
        if (wr_en === 1'b1) begin
            e.c = cyc; e.a = wr_addr; e.d = wr_data;
            wq.push_back(e);
        end
        if (start === 1'b1) sq.push_back(cyc);
    end

    // reference model state
    logic [7:0] m_addr, m_mode;
    bit         m_busy, m_err;
    int         m_ptr;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 = WR, 1 = RD, 2 = excute
    task automatic strobe(input int which, input bit c, input bit cdv,
                          input logic [7:0] d, output int t0,
                          output logic [5:0] sa, output logic [7:0] sd);
        @(negedge clk);
        bus.cs = c; bus.cd = cdv; bus.pico_din = d;
        @(negedge clk);
        t0 = cyc;
        case (which)
            0: bus.wr = 1'b1;
            1: bus.rd = 1'b1;
            default: bus.excute = 1'b1;
        endcase
        repeat (4) @(negedge clk);
        sa = rd_addr;
        sd = bus.pico_dout;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.excute = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic model_reset();
        m_addr = '0; m_mode = '0; m_busy = 0; m_err = 0; m_ptr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.wr = 0; bus.rd = 0; bus.excute = 0; done = 0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        model_reset();
    endtask

    // op: 0 addr write, 1 data write, 2 excute, 3 done, 4 read
    task automatic do_op(input int op, input bit c, input logic [7:0] d);
        int t0;
        logic [5:0] sa;
        logic [7:0] sd;
        bit ew, es;
        logic [7:0] ea, ed;
        wq.delete(); sq.delete();
        ew = 0; es = 0; ea = '0; ed = '0;
        case (op)
            0, 1: begin
                strobe(0, c, op == 0, d, t0, sa, sd);
                if (c) begin
                    if (m_busy) m_err = 1;
                    else if (op == 0) m_addr = d;
                    else if (m_addr == MODE_A) m_mode = d;
                    else begin
                        ew = 1; ea = m_addr; ed = d;
`ifdef ADDR_AUTOINC_EN
                        m_addr = m_addr + 8'd1;
`endif
                    end
                end
            end
            2: begin
                strobe(2, c, 1'b0, d, t0, sa, sd);
                if (c) begin
                    if (m_busy) m_err = 1;
                    else begin es = 1; m_busy = 1; m_ptr = 0; end
                end
            end
            3: begin
                @(negedge clk) done = 1'b1;
                @(negedge clk) done = 1'b0;
                tick(3);
                m_busy = 0;
                t0 = 0;
            end
            default: begin
                strobe(1, c, 1'b0, d, t0, sa, sd);
                chk("rd_addr_hi", sa, m_ptr);
                chk("dout_hi", sd, mem[m_ptr]);
                chk("oe", bus.pico_oe, c);
                if (c) begin
                    if (m_busy) m_err = 1;
                    else m_ptr = (m_ptr + 1) % DEPTH;
                end
            end
        endcase
        chk("wen_cnt", wq.size(), ew);
        if (ew && wq.size() == 1) begin
            chk("wen_addr", wq[0].a, ea);
            chk("wen_data", wq[0].d, ed);
            chk("wen_lat", wq[0].c - t0, 3);
        end
        chk("start_cnt", sq.size(), es);
        if (es && sq.size() == 1) chk("start_lat", sq[0] - t0, 3);
        chk("busy", busy, m_busy);
        chk("err", err, m_err);
        chk("mode", mode, m_mode);
        chk("rd_addr", rd_addr, m_ptr);
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, "_wen"}, wr_en, 0);
        chk({n, "_waddr"}, wr_addr, 0);
        chk({n, "_wdata"}, wr_data, 0);
        chk({n, "_mode"}, mode, 0);
        chk({n, "_start"}, start, 0);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_rdaddr"}, rd_addr, 0);
        chk({n, "_err"}, err, 0);
        chk({n, "_dout"}, bus.pico_dout, 0);
        chk({n, "_oe"}, bus.pico_oe, 0);
    endtask

    typedef struct {
        bit         cs;
        bit         cd;
        logic [7:0] d;
        bit         ew;
        logic [7:0] ea;
        logic [7:0] ed;
        logic [7:0] emode;
    } vec_t;

    function automatic vec_t mk(bit cs, bit cd, logic [7:0] d, bit ew,
                                logic [7:0] ea, logic [7:0] ed,
                                logic [7:0] em);
        vec_t v;
        v.cs = cs; v.cd = cd; v.d = d; v.ew = ew;
        v.ea = ea; v.ed = ed; v.emode = em;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int t0;
        logic [5:0] sa;
        logic [7:0] sd;

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        bus.cs = 0; bus.wr = 0; bus.rd = 0; bus.cd = 0;
        bus.excute = 0; bus.dir = 1; bus.pico_din = 0; done = 0;
        model_reset();

        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(4);

        tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h11, 1, 8'h00, 8'h11, 0));
        tbl.push_back(mk(1, 1, 8'h40, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'h40, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 0, 8'h02, 0, 0, 0, 8'h02));
        tbl.push_back(mk(1, 1, 8'h00, 0, 0, 0, 8'h02));
        tbl.push_back(mk(1, 0, 8'h02, 1, 8'h00, 8'h02, 8'h02));
        tbl.push_back(mk(1, 1, 8'h01, 0, 0, 0, 8'h02));
        tbl.push_back(mk(1, 0, 8'h03, 1, 8'h01, 8'h03, 8'h02));
        tbl.push_back(mk(1, 1, 8'h02, 0, 0, 0, 8'h02));
        tbl.push_back(mk(1, 0, 8'h04, 1, 8'h02, 8'h04, 8'h02));
        tbl.push_back(mk(1, 1, 8'h20, 0, 0, 0, 8'h02));
        tbl.push_back(mk(1, 0, 8'h05, 1, 8'h20, 8'h05, 8'h02));
        tbl.push_back(mk(1, 1, 8'h21, 0, 0, 0, 8'h02));
        tbl.push_back(mk(1, 0, 8'h06, 1, 8'h21, 8'h06, 8'h02));
        tbl.push_back(mk(1, 1, 8'h22, 0, 0, 0, 8'h02));
        tbl.push_back(mk(1, 0, 8'h07, 1, 8'h22, 8'h07, 8'h02));

        foreach (tbl[i]) begin
            wq.delete();
            strobe(0, tbl[i].cs, tbl[i].cd, tbl[i].d, t0, sa, sd);
            chk("tbl_wen_cnt", wq.size(), tbl[i].ew);
            if (tbl[i].ew && wq.size() == 1) begin
                chk("tbl_waddr", wq[0].a, tbl[i].ea);
                chk("tbl_wdata", wq[0].d, tbl[i].ed);
                chk("tbl_wlat", wq[0].c - t0, 3);
            end
            chk("tbl_mode", mode, tbl[i].emode);
            chk("tbl_err", err, 0);
        end

        // start/done, then 40 reads, then a wrap over 65 reads
        m_mode = 8'h02;
        m_addr = 8'h22;
`ifdef ADDR_AUTOINC_EN
        m_addr = 8'h23;
`endif
        do_op(2, 1, 0);
        chk("busy_after_start", busy, 1);
        do_op(3, 1, 0);
        chk("busy_after_done", busy, 0);
        for (int k = 0; k < 40; k++) do_op(4, 1, 0);
        chk("ptr_after_40", rd_addr, 40);
        do_op(2, 1, 0);
        do_op(3, 1, 0);
        for (int k = 0; k < 65; k++) do_op(4, 1, 0);
        chk("ptr_after_wrap", rd_addr, 1);

        do_reset();
        for (int i = 0; i < 150; i++) begin
            int op;
            bit c;
            logic [7:0] d;
            op = $urandom_range(0, 4);
            c  = ($urandom_range(0, 5) != 0);
            d  = ($urandom_range(0, 3) == 0) ? MODE_A : 8'($urandom);
            do_op(op, c, d);
        end

        // busy protection
        do_reset();
        chk("err_clear", err, 0);
        do_op(1, 1, 8'h33);
        do_op(2, 1, 0);
        do_op(0, 1, 8'h05);
        do_op(1, 1, 8'h09);
        do_op(2, 1, 0);
        chk("err_sticky", err, 1);

        // reset asserted while WR is high
        @(negedge clk);
        bus.cs = 1; bus.cd = 0; bus.pico_din = 8'h55;
        @(negedge clk) bus.wr = 1'b1;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midwr");
        rst_n = 1'b1;
        wq.delete();
        tick(8);
        bus.wr = 1'b0;
        tick(6);
        chk("midwr_no_wen", wq.size(), 0);
        model_reset();
        do_op(1, 1, 8'h66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
